// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT write-back path:
//   - default ring size and derived stage count
//   - width of the stage tag carried with each butterfly result
//   - write-back FSM state type
//   - in-place Cooley-Tukey address pair helper
// No ports (package).
// ---------------------------------------------------------------------------
package ntt_pkg;

   localparam int NTT_RING_SIZE = 256;
   localparam int NTT_LOG_N     = $clog2(NTT_RING_SIZE);
   localparam int STAGE_W       = 12;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } wb_state_t;

   typedef struct packed {
      logic [31:0] addr_a;
      logic [31:0] addr_b;
   } addr_pair_t;

   // Butterfly k of stage s touches the element pair that sits 2^s apart
   // inside group (k >> s); each group spans 2^(s+1) elements. Bit s of
   // addr_a is always clear, so OR-ing in half gives addr_b without a carry.
   function automatic addr_pair_t bfly_addr(input logic [STAGE_W-1:0] s,
                                            input logic [31:0] k);
      logic [31:0] half;
      logic [31:0] j;
      logic [31:0] grp;
      addr_pair_t  p;
      half     = 32'd1 << s;
      j        = k & (half - 32'd1);
      grp      = k >> s;
      p.addr_a = (grp << (s + 12'd1)) | j;
      p.addr_b = p.addr_a | half;
      return p;
   endfunction

endpackage

// File: rtl/ntt_writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// ntt_writeback_ctrl_if
// Bundles the butterfly-result input bus and the dual-port RAM write bus.
//   in_valid/in_even/in_odd/in_stage : butterfly pipeline -> controller
//   wr_en/wr_addr_a/wr_addr_b/wr_data_a/wr_data_b : controller -> RAM
// Modports:
//   master : the side producing butterfly results and consuming RAM writes
//   slave  : the write-back controller
// ---------------------------------------------------------------------------
interface ntt_writeback_ctrl_if
   import ntt_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LOG_N  = NTT_LOG_N
);

   logic                in_valid;
   logic [DATA_W-1:0]   in_even;
   logic [DATA_W-1:0]   in_odd;
   logic [STAGE_W-1:0]  in_stage;

   logic                wr_en;
   logic [LOG_N-1:0]    wr_addr_a;
   logic [LOG_N-1:0]    wr_addr_b;
   logic [DATA_W-1:0]   wr_data_a;
   logic [DATA_W-1:0]   wr_data_b;

   modport master (
      output in_valid, in_even, in_odd, in_stage,
      input  wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
   );

   modport slave (
      input  in_valid, in_even, in_odd, in_stage,
      output wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
   );

endinterface

// File: rtl/ntt_wb_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_wb_addr_gen
// Butterfly/stage counters and registered write-address generator.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : return counters to stage 0 / butterfly 0 (addresses hold)
//   advance     : one butterfly accepted this cycle
//   addr_a/b    : registered write addresses, updated on advance
//   stage       : stage currently being written
//   stage_end   : registered pulse alongside the last write of a stage
//   xform_end   : registered pulse alongside the last write of the last stage
// ---------------------------------------------------------------------------
module ntt_wb_addr_gen
   import ntt_pkg::*;
#(
   parameter  int RING_SIZE = NTT_RING_SIZE,
   localparam int LOG_N     = $clog2(RING_SIZE),
   localparam int K_W       = LOG_N - 1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                advance,
   output logic [LOG_N-1:0]    addr_a,
   output logic [LOG_N-1:0]    addr_b,
   output logic [STAGE_W-1:0]  stage,
   output logic                stage_end,
   output logic                xform_end
);

   localparam logic [K_W-1:0]     K_LAST = K_W'(RING_SIZE / 2 - 1);
   localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG_N - 1);

   logic [K_W-1:0]   k;
   logic [LOG_N-1:0] next_a;
   logic [LOG_N-1:0] next_b;
   logic             last_k;
   logic             last_stage;

   // The helper returns {addr_a, addr_b} as 32-bit fields; the pair is
   // narrowed straight from the call so no wide intermediate is kept.
   assign next_a     = LOG_N'(bfly_addr(stage, 32'(k)) >> 32);
   assign next_b     = LOG_N'(bfly_addr(stage, 32'(k)));
   assign last_k     = (k == K_LAST);
   assign last_stage = (stage == S_LAST);

   // Counter and address register. The stage counter stops on the last
   // stage so the top level can still report it during the DONE cycle;
   // clear brings it back to zero when the transform is retired or rearmed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k         <= '0;
         stage     <= '0;
         addr_a    <= '0;
         addr_b    <= '0;
         stage_end <= 1'b0;
         xform_end <= 1'b0;
      end else if (clear) begin
         k         <= '0;
         stage     <= '0;
         stage_end <= 1'b0;
         xform_end <= 1'b0;
      end else begin
         stage_end <= 1'b0;
         xform_end <= 1'b0;
         if (advance) begin
            addr_a <= next_a;
            addr_b <= next_b;
            if (last_k) begin
               k         <= '0;
               stage_end <= 1'b1;
               if (last_stage) begin
                  xform_end <= 1'b1;
               end else begin
                  stage <= stage + 1'b1;
               end
            end else begin
               k <= k + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ntt_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_writeback_ctrl
// Write side of the NTT engine: takes butterfly result pairs from the
// pipeline and writes them back in place, one pair per cycle.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : one-cycle pulse arming a new transform (ignored when busy)
//   bus         : slave side of ntt_writeback_ctrl_if (results in, RAM out)
//   stage       : stage index currently being written
//   stage_done  : pulse with the final write of each stage
//   done        : pulse one cycle after the final write of the transform
//   busy        : high from start until done
//   err         : sticky stage-tag mismatch / valid-while-idle flag
// ---------------------------------------------------------------------------
module ntt_writeback_ctrl
   import ntt_pkg::*;
#(
   parameter  int RING_SIZE = NTT_RING_SIZE,
   parameter  int DATA_W    = 32,
   localparam int LOG_N     = $clog2(RING_SIZE)
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   ntt_writeback_ctrl_if.slave bus,
   output logic [STAGE_W-1:0]  stage,
   output logic                stage_done,
   output logic                done,
   output logic                busy,
   output logic                err
);

   wb_state_t        state_q;
   wb_state_t        state_d;
   logic             advance;
   logic             clear;
   logic             arm;
   logic             stray_valid;
   logic             xform_end;
   logic [LOG_N-1:0] addr_a;
   logic [LOG_N-1:0] addr_b;

   // A result is consumed only while collecting; once the final butterfly
   // has been taken, anything else arriving is treated like a stray valid.
   assign arm         = (state_q == IDLE) && start;
   assign advance     = (state_q == COLLECT) && bus.in_valid && !xform_end;
   assign stray_valid = bus.in_valid && !advance && !arm;
   assign clear       = arm || (state_q == DONE);

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   ntt_wb_addr_gen #(
      .RING_SIZE (RING_SIZE)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .advance   (advance),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .stage     (stage),
      .stage_end (stage_done),
      .xform_end (xform_end)
   );

   assign bus.wr_addr_a = addr_a;
   assign bus.wr_addr_b = addr_b;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. COLLECT leaves one cycle after the final write so
   // that done lands on the cycle following the last wr_en.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (xform_end) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Data capture: the pair is registered together with the address so the
   // RAM sees strobe, address and data on the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.wr_en     <= 1'b0;
         bus.wr_data_a <= '0;
         bus.wr_data_b <= '0;
      end else begin
         bus.wr_en <= advance;
         if (advance) begin
            bus.wr_data_a <= bus.in_even;
            bus.wr_data_b <= bus.in_odd;
         end
      end
   end

   // Sticky error flag, cleared only by arming a new transform. A wrong tag
   // does not block the write; the internal stage still selects addresses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (arm) begin
         err <= 1'b0;
      end else if (stray_valid) begin
         err <= 1'b1;
      end else if (advance && (bus.in_stage != stage)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ntt_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ntt_writeback_ctrl
// Directed bench for ntt_writeback_ctrl at RING_SIZE=8. Expected writes are
// queued when a butterfly is driven and retired when wr_en is observed.
// ---------------------------------------------------------------------------
module tb_ntt_writeback_ctrl;
   import ntt_pkg::*;

   localparam int N      = 8;
   localparam int HALF_N = N / 2;
   localparam int LOGN   = 3;
   localparam int DW     = 32;

   typedef struct {
      int          cyc;
      logic [2:0]  a;
      logic [2:0]  b;
      logic [31:0] da;
      logic [31:0] db;
      logic        sd;
   } exp_t;

   logic               clk;
   logic               reset;
   logic               start;
   logic [STAGE_W-1:0] stage;
   logic               stage_done;
   logic               done;
   logic               busy;
   logic               err;

   ntt_writeback_ctrl_if #(.DATA_W(DW), .LOG_N(LOGN)) bus ();

   ntt_writeback_ctrl #(
      .RING_SIZE (N),
      .DATA_W    (DW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus.slave),
      .stage      (stage),
      .stage_done (stage_done),
      .done       (done),
      .busy       (busy),
      .err        (err)
   );

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          exp_s;
   int          exp_k;
   int          last_cyc;
   logic [31:0] last_da = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input int tag,
                                input logic [31:0] even, input logic [31:0] odd,
                                input logic st);
      bus.in_valid = valid;
      bus.in_stage = STAGE_W'(tag);
      bus.in_even  = even;
      bus.in_odd   = odd;
      start        = st;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      start        = 1'b0;
   endtask

   // Independent model of the in-place schedule: group/offset by division.
   task automatic push_expected(input logic [31:0] da, input logic [31:0] db);
      exp_t e;
      int   half;
      int   a_i;
      half   = 1 << exp_s;
      a_i    = (exp_k / half) * 2 * half + (exp_k % half);
      e.cyc  = cyc + 1;
      e.a    = 3'(a_i);
      e.b    = 3'(a_i + half);
      e.da   = da;
      e.db   = db;
      e.sd   = (exp_k == HALF_N - 1);
      sb_q.push_back(e);
      last_cyc = e.cyc;
      if (exp_k == HALF_N - 1) begin
         exp_k = 0;
         if (exp_s < LOGN - 1) exp_s++;
      end else begin
         exp_k++;
      end
   endtask

   // Drives one transform; stops early after stop_after valids if >= 0.
   task automatic run_transform(input int gap, input int bad_idx,
                                input int restart_idx, input int stop_after);
      logic [31:0] d0;
      logic [31:0] d1;
      int          tag;
      applyStimulus(1'b0, 0, 32'h0, 32'h0, 1'b1);
      checkOutput("busy_after_start", busy, 1);
      checkOutput("err_after_start", err, 0);
      exp_s = 0;
      exp_k = 0;
      for (int i = 0; i < LOGN * HALF_N; i++) begin
         if (stop_after >= 0 && i == stop_after) return;
         checkOutput("stage_out", stage, exp_s);
         if (i == bad_idx) checkOutput("err_before_bad_tag", err, 0);
         tag = (i == bad_idx) ? exp_s + 1 : exp_s;
         d0  = $urandom;
         d1  = $urandom;
         push_expected(d0, d1);
         applyStimulus(1'b1, tag, d0, d1, (i == restart_idx));
         if (i == bad_idx) checkOutput("err_after_bad_tag", err, 1);
         if (i < LOGN * HALF_N - 1) begin
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, exp_s, 32'h0, 32'h0, 1'b0);
         end
      end
   endtask

   task automatic wait_done();
      int done_cyc;
      done_cyc = -1;
      for (int i = 0; i < 8 && done_cyc < 0; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_cyc = cyc;
      end
      checkOutput("done_cycle", 64'(done_cyc), 64'(last_cyc + 1));
      @(negedge clk);
      checkOutput("done_single_cycle", done, 0);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("stage_back_to_zero", stage, 0);
      checkOutput("scoreboard_drained", 64'(sb_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_wr_en"}, bus.wr_en, 0);
      checkOutput({tag, "_addr_a"}, bus.wr_addr_a, 0);
      checkOutput({tag, "_addr_b"}, bus.wr_addr_b, 0);
      checkOutput({tag, "_data_a"}, bus.wr_data_a, 0);
      checkOutput({tag, "_data_b"}, bus.wr_data_b, 0);
      checkOutput({tag, "_stage"}, stage, 0);
      checkOutput({tag, "_stage_done"}, stage_done, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_err"}, err, 0);
   endtask

   // Write monitor: every observed strobe retires the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_wr_en", bus.wr_en, 0);
            end else begin
               mon_e = sb_q.pop_front();
               checkOutput("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
               checkOutput("wr_addr_a", bus.wr_addr_a, mon_e.a);
               checkOutput("wr_addr_b", bus.wr_addr_b, mon_e.b);
               checkOutput("wr_data_a", bus.wr_data_a, mon_e.da);
               checkOutput("wr_data_b", bus.wr_data_b, mon_e.db);
               checkOutput("stage_done_with_wr", stage_done, mon_e.sd);
               last_da = mon_e.da;
            end
         end else begin
            checkOutput("stage_done_without_wr", stage_done, 0);
            if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
               checkOutput("missing_wr_en", bus.wr_en, 1);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_even  = '0;
      bus.in_odd   = '0;
      bus.in_stage = '0;
      #12;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] back-to-back transform");
      run_transform(0, -1, -1, -1);
      wait_done();
      checkOutput("err_clean_run", err, 0);

      $display("[TB] valid while idle");
      applyStimulus(1'b1, 0, 32'hA5, 32'h5A, 1'b0);
      checkOutput("idle_no_wr_en", bus.wr_en, 0);
      checkOutput("idle_data_held", bus.wr_data_a, last_da);
      checkOutput("idle_err_set", err, 1);

      $display("[TB] gapped transform");
      run_transform(1, -1, -1, -1);
      wait_done();
      checkOutput("err_gapped_run", err, 0);

      $display("[TB] stage tag mismatch");
      run_transform(0, 1, -1, -1);
      wait_done();
      checkOutput("err_sticky", err, 1);

      $display("[TB] start while busy");
      run_transform(0, -1, 5, -1);
      wait_done();
      checkOutput("err_restart_run", err, 0);

      $display("[TB] reset mid-transform");
      run_transform(0, -1, -1, 6);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("mid_reset");
      sb_q.delete();
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_transform(0, -1, -1, -1);
      wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
